// File: rtl/eei_pkg.sv
// Shared execution-environment types used across the pipeline front end.
package eei;

    localparam int XLEN       = 64;
    localparam int INST_BYTES = 4;

    typedef logic [XLEN-1:0] Addr;
    typedef logic [31:0]     Inst;

    // One fetched instruction together with the PC it was read from.
    typedef struct packed {
        Addr pc;
        Inst bits;
    } FetchEntry;

endpackage

// File: rtl/inst_fetcher_fifo.sv
// Generic synchronous FIFO with flush; flush wins over push and pop.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]    CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/inst_fetcher.sv
// Fetch stage: sequential PC generation, single-outstanding bus requests,
// buffered {pc, inst} hand-off to decode, and flush on redirect.
//
// state | meaning
// REQ   | fetch_pc presented on the bus, waiting for acceptance
// WAIT  | one request accepted, waiting for its read response
module inst_fetcher
    import eei::*;
#(
    parameter int  DEPTH    = 4,
    parameter Addr RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        i_membus_valid,
    input  logic        i_membus_ready,
    output logic [63:0] i_membus_addr,
    input  logic        i_membus_rvalid,
    input  logic [31:0] i_membus_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [63:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        redirect,
    input  logic [63:0] redirect_pc
);
    localparam logic [0:0] REQ  = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;
    localparam int         CW   = $clog2(DEPTH) + 1;

    logic [0:0]    state;
    Addr           fetch_pc;
    Addr           req_pc;
    logic          discard;
    logic          accept;
    logic          push;
    logic          pop;
    FetchEntry     wentry;
    FetchEntry     head;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          unused_pc_lsbs;

    // Low PC bits of a redirect target are forced to zero, so never read.
    assign unused_pc_lsbs = ^redirect_pc[1:0];

    // Requests only go out when a slot is guaranteed for the response;
    // rst gating keeps both valids low while reset is held.
    assign i_membus_valid = rst && (state == REQ) && !redirect
                            && (fifo_count < CW'(DEPTH));
    assign i_membus_addr  = fetch_pc;
    assign accept         = i_membus_valid && i_membus_ready;

    assign wentry   = '{pc: req_pc, bits: i_membus_rdata};
    assign push     = (state == WAIT) && i_membus_rvalid && !discard
                      && !redirect && !fifo_full;
    assign if_valid = rst && !fifo_empty && !redirect;
    assign pop      = if_valid && if_ready;
    assign if_pc    = head.pc;
    assign if_inst  = head.bits;

    fifo #(
        .WIDTH ($bits(FetchEntry)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (push),
        .wdata (wentry),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Fetch FSM, PC register and stale-response tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= REQ;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            discard  <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[63:2], 2'b00};
            if (state == WAIT) begin
                if (i_membus_rvalid) begin
                    // The outstanding response lands now and is dropped,
                    // so nothing stale remains in flight.
                    state   <= REQ;
                    discard <= 1'b0;
                end else begin
                    discard <= 1'b1;
                end
            end
        end else begin
            case (state)
                REQ: begin
                    if (accept) begin
                        req_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + Addr'(INST_BYTES);
                        state    <= WAIT;
                    end
                end
                default: begin
                    if (i_membus_rvalid) begin
                        discard <= 1'b0;
                        state   <= REQ;
                    end
                end
            endcase
        end
    end

endmodule
